// File: rtl/compat_pkg.sv
// Shared types and helpers for the iterative normalizer.
// Holds the FSM state encoding and the count-width derivation.
package compat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } norm_state_t;

  // The count must reach WIDTH itself for an all-zero input, hence one extra bit.
  function automatic int count_width(input int widthdist);
    return widthdist + 1;
  endfunction

endpackage

// File: rtl/compat_norm_step.sv
// One binary-search step: test the 2^k-bit span at the chosen edge and shift past it if empty.
// Purely combinational; the caller registers the returned work word.
module compat_norm_step #(
  parameter int WIDTH     = 32,
  parameter int WIDTHDIST = 5
) (
  input  logic [WIDTH-1:0]     work_i,
  input  logic [WIDTHDIST-1:0] k_i,
  input  logic                 dir_i,
  output logic [WIDTH-1:0]     work_o,
  output logic                 hit_o
);

  localparam int SW = WIDTHDIST + 1;

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] shifted;
  logic [SW-1:0]    span;

  always_comb begin
    ones = '1;
    span = SW'(1) << k_i;
    if (!dir_i) begin
      mask    = ~(ones >> span);
      shifted = work_i << span;
    end else begin
      mask    = ~(ones << span);
      shifted = work_i >> span;
    end
    hit_o  = (work_i & mask) == '0;
    work_o = hit_o ? shifted : work_i;
  end

endmodule

// File: rtl/compat_normalize.sv
// Iterative normalizer: finds leading/trailing zero count and normalized word, one distance bit per cycle.
// Latency WIDTHDIST+1 cycles; result held in DONE until out_ready, no new accept until back in IDLE.
module compat_normalize
  import compat_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int WIDTHDIST = 5
) (
  input  logic                                clock,
  input  logic                                aclr,
  input  logic                                clken,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    data,
  input  logic                                direction,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [count_width(WIDTHDIST)-1:0]   count,
  output logic [WIDTH-1:0]                    result,
  output logic                                zero
);

  localparam int CW = count_width(WIDTHDIST);
  localparam int KW = WIDTHDIST;

  norm_state_t      state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [KW-1:0]    k_q, k_d;
  logic             dir_q, dir_d;

  logic [WIDTH-1:0] step_work;
  logic             step_hit;

  compat_norm_step #(
    .WIDTH     (WIDTH),
    .WIDTHDIST (WIDTHDIST)
  ) u_step (
    .work_i (work_q),
    .k_i    (k_q),
    .dir_i  (dir_q),
    .work_o (step_work),
    .hit_o  (step_hit)
  );

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q <= IDLE;
      work_q  <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    acc_d   = acc_q;
    k_d     = k_q;
    dir_d   = dir_q;
    if (clken) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_d  = data;
            dir_d   = direction;
            acc_d   = '0;
            k_d     = KW'(WIDTHDIST - 1);
            state_d = BUSY;
          end
        end
        BUSY: begin
          work_d = step_work;
          if (step_hit) acc_d = acc_q + (CW'(1) << k_q);
          if (k_q == '0) state_d = DONE;
          else           k_d     = k_q - KW'(1);
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decode from state and registers only, so they read as zero outside DONE.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    zero      = out_valid && (work_q == '0);
    result    = out_valid ? work_q : '0;
    count     = '0;
    if (out_valid) count = zero ? CW'(WIDTH) : acc_q;
  end

endmodule

// File: tb/tb_compat_normalize.sv
// Directed bench for compat_normalize with hand-computed expectations.
module tb_compat_normalize;

  logic        clock = 1'b0;
  logic        aclr;
  logic        clken;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data;
  logic        direction;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  count;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  compat_normalize #(.WIDTH(32), .WIDTHDIST(5)) dut (
    .clock     (clock),
    .aclr      (aclr),
    .clken     (clken),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data      (data),
    .direction (direction),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .result    (result),
    .zero      (zero)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_req(input logic [31:0] d, input logic dr);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("in_ready_before_req", in_ready, 1);
    in_valid  = 1'b1;
    data      = d;
    direction = dr;
    @(negedge clock);
    in_valid  = 1'b0;
  endtask

  // Latency counts the accept cycle as cycle 1.
  task automatic wait_done(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic finish_req(input string tag);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check({tag, "_post_out_valid"}, out_valid, 0);
    check({tag, "_post_in_ready"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [31:0] d, input logic dr,
                     input logic [5:0] exp_cnt, input logic [31:0] exp_res, input logic exp_zero);
    int lat;
    start_req(d, dr);
    wait_done(1, lat);
    check({tag, "_latency"}, lat, 6);
    check({tag, "_count"}, count, exp_cnt);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, zero, exp_zero);
    finish_req(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    aclr      = 1'b1;
    clken     = 1'b1;
    in_valid  = 1'b0;
    data      = '0;
    direction = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    @(negedge clock);
    aclr = 1'b0;
    @(negedge clock);

    run("lz_bit16",   32'h0001_0000, 1'b0, 6'd15, 32'h8000_0000, 1'b0);
    run("lz_bit0",    32'h0000_0001, 1'b0, 6'd31, 32'h8000_0000, 1'b0);
    run("tz_bit8",    32'h0000_0100, 1'b1, 6'd8,  32'h0000_0001, 1'b0);
    run("zero_lz",    32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 1'b1);
    run("zero_tz",    32'h0000_0000, 1'b1, 6'd32, 32'h0000_0000, 1'b1);
    run("lz_already", 32'h8000_0000, 1'b0, 6'd0,  32'h8000_0000, 1'b0);
    run("tz_msb",     32'h8000_0000, 1'b1, 6'd31, 32'h0000_0001, 1'b0);
    run("tz_nibble",  32'h00F0_0000, 1'b1, 6'd20, 32'h0000_000F, 1'b0);
    run("lz_nibble",  32'h00F0_0000, 1'b0, 6'd8,  32'hF000_0000, 1'b0);
    run("tz_already", 32'h0000_0003, 1'b1, 6'd0,  32'h0000_0003, 1'b0);

    // Backpressure: result must hold while out_ready is low.
    start_req(32'h0001_0000, 1'b0);
    wait_done(1, lat);
    check("bp_latency", lat, 6);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_count", count, 15);
      check("bp_result", result, 32'h8000_0000);
    end
    // clken low blocks the handshake even with out_ready high.
    clken     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("bp_clken_hold_valid", out_valid, 1);
    check("bp_clken_hold_count", count, 15);
    clken = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);

    // Reset in the middle of BUSY discards the request.
    start_req(32'h1234_5678, 1'b0);
    repeat (2) @(negedge clock);
    check("busy_in_ready", in_ready, 0);
    #2 aclr = 1'b1;
    #1;
    check("aclr_busy_in_ready", in_ready, 1);
    check("aclr_busy_out_valid", out_valid, 0);
    check("aclr_busy_count", count, 0);
    #1 aclr = 1'b0;
    @(negedge clock);
    run("post_aclr", 32'h4000_0000, 1'b0, 6'd1, 32'h8000_0000, 1'b0);

    // Reset while holding a result clears the outputs immediately.
    start_req(32'h0000_0001, 1'b0);
    wait_done(1, lat);
    check("done_pre_aclr_count", count, 31);
    #2 aclr = 1'b1;
    #1;
    check("aclr_done_out_valid", out_valid, 0);
    check("aclr_done_count", count, 0);
    check("aclr_done_result", result, 0);
    check("aclr_done_in_ready", in_ready, 1);
    #1 aclr = 1'b0;
    @(negedge clock);

    // clken stall inside BUSY with the direction port changing underneath.
    start_req(32'h0000_0100, 1'b1);
    @(negedge clock);
    direction = 1'b0;
    clken     = 1'b0;
    repeat (4) @(negedge clock);
    check("stall_hold_in_ready", in_ready, 0);
    check("stall_hold_out_valid", out_valid, 0);
    clken = 1'b1;
    wait_done(6, lat);
    check("stall_latency", lat, 10);
    check("stall_count", count, 8);
    check("stall_result", result, 32'h0000_0001);
    check("stall_zero", zero, 0);
    finish_req("stall");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
